// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fft_pkg
//  Description : Shared types and default sizes for the 8-point FFT datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package fft_pkg;

    // Default frame size (log2) and complex sample width
    localparam int c_fft_n     = 3;
    localparam int c_sample_w  = 32;
    localparam int c_frame_len = 2 ** c_fft_n;

    // Complex sample: real part in the upper half, imaginary in the lower half
    typedef struct packed {
        logic [c_sample_w/2-1:0] re;
        logic [c_sample_w/2-1:0] im;
    } sample_t;

    // A whole frame in natural order, entry k is the k-th sample
    typedef sample_t [c_frame_len-1:0] frame_t;

    // Framer control states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } framer_state_t;

endpackage
`default_nettype wire

// File: rtl/fft_input_framer.sv
`default_nettype none
// ============================================================================
//  Module      : fft_input_framer
//  Description : Packs streamed complex samples into a 2**N-word frame,
//                holds the frame until the consumer takes it and flags
//                frames whose s_last marker disagrees with the frame length.
//  Revision    : 1.0 - initial release
// ============================================================================
module fft_input_framer
    import fft_pkg::*;
#(
    parameter int N        = c_fft_n,
    parameter int SAMPLE_W = c_sample_w
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [SAMPLE_W-1:0]              s_data,
    input  logic                             s_valid,
    input  logic                             s_last,
    output logic                             s_ready,
    output logic [2**N-1:0][SAMPLE_W-1:0]    m_frame,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic                             frame_err
);

    // Index of the final slot in the frame buffer
    localparam logic [N-1:0] c_idx_last = '1;

    framer_state_t                    r_state;
    framer_state_t                    w_state_nxt;
    logic [N-1:0]                     r_idx;
    logic [N-1:0]                     w_idx_nxt;
    logic                             r_s_ready;
    logic                             w_s_ready_nxt;
    logic                             r_m_valid;
    logic                             w_m_valid_nxt;
    logic                             r_frame_err;
    logic                             w_frame_err_nxt;
    logic                             w_wr_en;
    logic [2**N-1:0][SAMPLE_W-1:0]    r_frame;

    // Control registers: state, write index and the registered handshake/error outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_s_ready   <= 1'b0;
            r_m_valid   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_s_ready   <= w_s_ready_nxt;
            r_m_valid   <= w_m_valid_nxt;
            r_frame_err <= w_frame_err_nxt;
        end
    end

    // Next-state logic; error pulse defaults low so it lasts exactly one cycle
    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_s_ready_nxt   = r_s_ready;
        w_m_valid_nxt   = r_m_valid;
        w_frame_err_nxt = 1'b0;
        w_wr_en         = 1'b0;
        case (r_state)
            IDLE: begin
                w_state_nxt   = COLLECT;
                w_s_ready_nxt = 1'b1;
            end
            COLLECT: begin
                if (s_valid && r_s_ready) begin
                    w_wr_en = 1'b1;
                    if (r_idx == c_idx_last) begin
                        // Frame full: emit it even if the source did not mark the end
                        w_idx_nxt       = '0;
                        w_state_nxt     = HOLD;
                        w_s_ready_nxt   = 1'b0;
                        w_m_valid_nxt   = 1'b1;
                        w_frame_err_nxt = ~s_last;
                    end else if (s_last) begin
                        // Short frame: drop it and restart; stale words stay in the buffer
                        w_idx_nxt       = '0;
                        w_frame_err_nxt = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (r_m_valid && m_ready) begin
                    w_state_nxt   = COLLECT;
                    w_m_valid_nxt = 1'b0;
                    w_s_ready_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt   = IDLE;
                w_idx_nxt     = '0;
                w_s_ready_nxt = 1'b0;
                w_m_valid_nxt = 1'b0;
            end
        endcase
    end

    // Frame buffer: written only on an accepted sample, so it is frozen during HOLD
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_frame <= '0;
        end else if (w_wr_en) begin
            r_frame[r_idx] <= s_data;
        end
    end

    assign s_ready   = r_s_ready;
    assign m_valid   = r_m_valid;
    assign frame_err = r_frame_err;
    assign m_frame   = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_fft_input_framer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fft_input_framer
//  Description : Scoreboard bench for fft_input_framer. The driver pushes each
//                completed frame and each expected error pulse; a monitor on
//                the falling edge pops and compares against the DUT outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_input_framer;

    typedef logic [7:0][31:0] frm_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    frm_t        m_frame;
    logic        m_valid;
    logic        m_ready;
    logic        frame_err;

    int   nchk;
    int   nfail;
    frm_t exp_q[$];
    frm_t cur;
    frm_t held;
    int   m_idx;
    logic exp_err;
    logic mon_en;
    logic prev_mv;
    logic prev_mr;
    logic rnd_done;

    fft_input_framer #(.N(3), .SAMPLE_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .m_frame   (m_frame),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .frame_err (frame_err)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Bench model of one accepted sample: builds frames and predicts error pulses
    task automatic model_accept(input logic [31:0] d, input logic last);
        cur[m_idx] = d;
        if (m_idx == 7) begin
            exp_q.push_back(cur);
            exp_err = ~last;
            m_idx   = 0;
        end else if (last) begin
            exp_err = 1'b1;
            m_idx   = 0;
        end else begin
            m_idx++;
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge
    task automatic drive_sample(input logic [31:0] d, input logic last);
        int waited;
        waited  = 0;
        s_data  = d;
        s_last  = last;
        s_valid = 1'b1;
        while (s_ready !== 1'b1) begin
            @(posedge clk);
            #1;
            waited++;
            if (waited > 400) begin
                nchk++;
                nfail++;
                $display("FAIL accept_timeout: s_ready stuck at %b, required 1 at %0t", s_ready, $time);
                s_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        model_accept(d, last);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: scoreboard pop on each new frame, stability while held, error pulse timing
    always @(negedge clk) begin
        if (mon_en) begin
            nchk++;
            if (frame_err !== exp_err) begin
                nfail++;
                $display("FAIL frame_err: got %b expected %b at %0t", frame_err, exp_err, $time);
            end
            exp_err = 1'b0;
            if (m_valid === 1'b1) begin
                nchk++;
                if (!prev_mv) begin
                    if (exp_q.size() == 0) begin
                        nfail++;
                        $display("FAIL unexpected_frame: got %h expected no frame at %0t", m_frame, $time);
                        held = m_frame;
                    end else begin
                        held = exp_q.pop_front();
                        if (m_frame !== held) begin
                            nfail++;
                            $display("FAIL frame_data: got %h expected %h at %0t", m_frame, held, $time);
                        end
                    end
                end else if (m_frame !== held) begin
                    nfail++;
                    $display("FAIL frame_stable: got %h expected %h at %0t", m_frame, held, $time);
                end
                check("s_ready_in_hold", {31'd0, s_ready}, 32'd0);
            end
            if (prev_mv && !prev_mr) check("m_valid_until_taken", {31'd0, m_valid}, 32'd1);
            if (prev_mv && prev_mr) begin
                check("m_valid_after_take", {31'd0, m_valid}, 32'd0);
                check("s_ready_after_take", {31'd0, s_ready}, 32'd1);
            end
            prev_mv = m_valid;
            prev_mr = m_ready;
        end
    end

    initial begin
        nchk     = 0;
        nfail    = 0;
        m_idx    = 0;
        cur      = '0;
        held     = '0;
        exp_err  = 1'b0;
        mon_en   = 1'b0;
        prev_mv  = 1'b0;
        prev_mr  = 1'b0;
        rnd_done = 1'b0;
        rst_n    = 1'b0;
        s_data   = '0;
        s_valid  = 1'b0;
        s_last   = 1'b0;
        m_ready  = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_s_ready", {31'd0, s_ready}, 32'd0);
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        nchk++;
        if (m_frame !== '0) begin
            nfail++;
            $display("FAIL rst_m_frame: got %h expected 0", m_frame);
        end
        mon_en = 1'b1;
        rst_n  = 1'b1;

        // Frame 1, consumer stalled: latency and hold stability
        for (int k = 0; k < 8; k++) drive_sample(32'((k + 1) << 16), k == 7);
        check("f1_m_valid_latency", {31'd0, m_valid}, 32'd1);
        check("f1_s_ready", {31'd0, s_ready}, 32'd0);
        s_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            s_data = $urandom;
            s_last = 1'(i & 1);
            idle(1);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        check("f1_still_valid", {31'd0, m_valid}, 32'd1);
        m_ready = 1'b1;
        idle(1);
        m_ready = 1'b0;
        check("f1_release_m_valid", {31'd0, m_valid}, 32'd0);
        check("f1_release_s_ready", {31'd0, s_ready}, 32'd1);

        // Frame 2 with consumer always ready
        m_ready = 1'b1;
        for (int k = 0; k < 8; k++) drive_sample(32'hA000_0000 | 32'(k), k == 7);
        idle(2);

        // Short frame then a clean frame
        drive_sample(32'h1111_0001, 1'b0);
        drive_sample(32'h1111_0002, 1'b0);
        drive_sample(32'h1111_0003, 1'b1);
        idle(3);
        check("short_no_m_valid", {31'd0, m_valid}, 32'd0);
        for (int k = 0; k < 8; k++) drive_sample(32'h2222_0000 | 32'(k * 3), k == 7);
        idle(1);

        // Unterminated frame; ninth sample must wait for the consumer
        m_ready = 1'b0;
        idle(1);
        for (int k = 0; k < 8; k++) drive_sample(32'h3333_0000 | 32'(k), 1'b0);
        check("long_m_valid", {31'd0, m_valid}, 32'd1);
        s_data  = 32'h4444_0000;
        s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("long_9th_blocked", {31'd0, s_ready}, 32'd0);
            idle(1);
        end
        m_ready = 1'b1;
        for (int k = 0; k < 8; k++) drive_sample(32'h4444_0000 | 32'(k), k == 7);
        idle(2);

        // Random source gaps and consumer stalls over 100 frames
        fork
            begin
                for (int f = 0; f < 100; f++) begin
                    for (int k = 0; k < 8; k++) begin
                        while ($urandom_range(1, 0) == 1) begin
                            s_valid = 1'b0;
                            s_last  = 1'($urandom_range(1, 0));
                            s_data  = $urandom;
                            idle(1);
                        end
                        drive_sample($urandom, k == 7);
                    end
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #2;
                    m_ready = 1'($urandom_range(1, 0));
                end
            end
        join
        idle(1);
        m_ready = 1'b1;
        for (int i = 0; i < 50 && (exp_q.size() != 0 || m_valid); i++) idle(1);
        check("random_drained", 32'(exp_q.size()), 32'd0);

        // Reset after the fifth sample, then a clean frame
        for (int k = 0; k < 5; k++) drive_sample(32'h5555_0000 | 32'(k), 1'b0);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        m_idx = 0;
        check("mid_rst_s_ready", {31'd0, s_ready}, 32'd0);
        check("mid_rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("mid_rst_frame_err", {31'd0, frame_err}, 32'd0);
        nchk++;
        if (m_frame !== '0) begin
            nfail++;
            $display("FAIL mid_rst_m_frame: got %h expected 0", m_frame);
        end
        s_data  = 32'h6666_0000;
        s_valid = 1'b1;
        idle(1);
        check("rel_edge1_s_ready", {31'd0, s_ready}, 32'd1);
        for (int k = 0; k < 8; k++) drive_sample(32'h6666_0000 | 32'(k), k == 7);
        for (int i = 0; i < 20 && (exp_q.size() != 0 || m_valid); i++) idle(1);
        check("final_drained", 32'(exp_q.size()), 32'd0);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
`default_nettype wire
